wb_sdram_arbiter: RTL and testbench
===================================

# wb_sdram_arbiter

Round-robin Wishbone B4 arbiter that lets NUM_MASTERS masters share the single Wishbone slave port of the SoC's SDRAM controller; typical masters are the picorv32 instruction and data ports and a DMA engine. It sits between the masters and the SDRAM controller in the `wb_clk` domain. It grants one master at a time and holds the grant for a whole bus cycle, including registered-feedback bursts. It routes ack/err only to the granted master and can optionally abort stalled cycles with a watchdog.

## Interface
- NUM_MASTERS, 3: number of requesting masters (2..8)
- AW, 32: address width
- DW, 32: data width; select width is DW/8
- TIMEOUT, 1024: watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN)

Ports:
- wb_clk_i  in  1  Wishbone clock
- wb_rst_n_i  in  1  reset, asynchronous, active-low
- m_cyc_i, m_stb_i, m_we_i  in  NUM_MASTERS each  per-master cycle, strobe and write enable
- m_adr_i  in  NUM_MASTERS*AW  packed addresses; master i occupies [i*AW +: AW]
- m_dat_i  in  NUM_MASTERS*DW  packed write data
- m_sel_i  in  NUM_MASTERS*DW/8  packed byte selects
- m_cti_i  in  NUM_MASTERS*3  packed cycle type identifiers
- m_bte_i  in  NUM_MASTERS*2  packed burst type extensions
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o, m_err_o  out  NUM_MASTERS  per-master termination
- s_cyc_o, s_stb_o, s_we_o  out  1  slave-side cycle, strobe and write enable
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_sel_o  out  DW/8  slave byte selects
- s_cti_o  out  3  slave cycle type identifier
- s_bte_o  out  2  slave burst type extension
- s_dat_i  in  DW  slave read data
- s_ack_i, s_err_i  in  1  slave termination
- grant_o  out  NUM_MASTERS  one-hot current grant (status/debug)

## Operation
- FSM states: IDLE, BUSY.
- IDLE: grant_o = 0 and all s_* outputs = 0. If any m_cyc_i is high, pick the first requester after `last` in round-robin order, wrapping N-1→0. Register grant_o to that master and go to BUSY.
- BUSY: all s_* outputs are combinationally muxed from the granted master. s_cyc_o = m_cyc_i[g]. The granted master receives m_ack_o[g] = s_ack_i and m_err_o[g] = s_err_i; ack/err to every other master is 0. m_dat_o = s_dat_i at all times.
- Grant is held while m_cyc_i[g] is high, independent of stb, cti or bte, so bursts and read-modify-write sequences are never split.
- When m_cyc_i[g] falls: set `last` = g, clear grant_o and return to IDLE. The bus always sees at least one idle cycle between owners.
- Other masters stay stalled (ack low) with no side effects on their signals.
- Reset: grant_o = 0, `last` = NUM_MASTERS-1 so master 0 wins first, FSM = IDLE. Any in-flight cycle is dropped and s_cyc_o goes low asynchronously.
- A new request arriving while in BUSY is queued implicitly and considered at the next IDLE.

## Timing
- Grant latency: m_cyc_i sampled high at edge n gives grant_o and s_cyc_o high after edge n (one-cycle latency from a request asserted during cycle n-1).
- s_cyc_o falls in the same cycle as m_cyc_i[g] (combinational). IDLE lasts exactly 1 cycle before the next grant.
- Back-to-back requests from different masters: minimum 2 cycles between the end of one grant and the s_cyc_o of the next (1 IDLE cycle plus 1 arbitration cycle).
- Simultaneous requests: round-robin order decides. A master that drops and re-raises cyc goes behind every other pending requester.

## Configuration
- Macro WB_ARB_TIMEOUT_EN.
- Defined: a counter clears on grant and on every s_ack_i/s_err_i, and increments while s_stb_o is high without termination. When it reaches TIMEOUT:
  - m_err_o[g] pulses for 1 cycle;
  - s_cyc_o and s_stb_o are forced low from that cycle on;
  - the FSM enters IDLE once m_cyc_i[g] falls, and `last` = g.
- Not defined: no counter and no forced error; a stalled slave holds the grant indefinitely.

## Structure
- Shared package wb_arb_pkg: state enum (IDLE, BUSY), Wishbone CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111), default TIMEOUT.
- Sub-module wb_rr_pick: combinational round-robin one-hot picker with inputs req[N] and last[N], output gnt[N].

## Test plan
- Reset release, only master 1 requests a single read: grant_o=3'b010 one cycle later; s_adr_o equals m1 address; m_ack_o=3'b010 when s_ack_i=1; m_dat_o=s_dat_i.
- Masters 0, 1 and 2 request simultaneously after reset: grants are issued in order 0, 1, 2, separated by one IDLE cycle each.
- Master 0 issues an 8-beat INCR burst while master 2 requests: master 2 is not granted until all 8 beats finish (cti EOB, cyc low) plus 1 idle cycle.
- Master 0 requests continuously while master 1 requests: grants alternate 0, 1, 0, 1 with no starvation.
- Assert wb_rst_n_i low mid-burst: s_cyc_o, grant_o, m_ack_o and m_err_o are 0 immediately; after release, master 0 has highest priority.
- With WB_ARB_TIMEOUT_EN and TIMEOUT=16, slave never acks: m_err_o[g] pulses at cycle 16 after s_stb_o rises; s_cyc_o low afterwards; the next master is granted after m_cyc_i[g] drops.

Source files
------------

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared types and constants for the Wishbone SDRAM arbiter:
//                FSM state encoding, Wishbone B4 CTI codes, default watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] c_CTI_INCR    = 3'b010;
    localparam logic [2:0] c_CTI_EOB     = 3'b111;

    localparam int c_DEFAULT_TIMEOUT = 1024;

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : wb_rr_pick
//  Description : Combinational round-robin picker. Given the request vector
//                and the one-hot last owner, returns a one-hot grant for the
//                first requester strictly after last, wrapping N-1 -> 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] last_i,
    output logic [N-1:0] gnt_o
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_req_hi;

    // Bits strictly above the last owner; empty when last is the top master,
    // which makes the search wrap around to master 0.
    assign w_mask   = ~((last_i << 1) - N'(1));
    assign w_req_hi = req_i & w_mask;

    // Lowest set bit of the upper requests, else lowest set bit overall.
    assign gnt_o = (|w_req_hi) ? (w_req_hi & (~w_req_hi + N'(1)))
                               : (req_i & (~req_i + N'(1)));

endmodule
`default_nettype wire

// File: rtl/wb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sdram_arbiter
//  Description : Round-robin Wishbone B4 arbiter letting NUM_MASTERS masters
//                share one SDRAM controller slave port. The grant is held for
//                the whole bus cycle (m_cyc high), ack/err are routed only to
//                the owner, and one idle cycle separates owners.
//                Optional watchdog: define WB_ARB_TIMEOUT_EN to abort a
//                strobe left unterminated for TIMEOUT cycles with an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_sdram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = c_DEFAULT_TIMEOUT
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int SW = DW / 8;
    localparam logic [NUM_MASTERS-1:0] c_LAST_RST = {1'b1, {(NUM_MASTERS-1){1'b0}}};

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] last_q,  last_d;
    logic [NUM_MASTERS-1:0] w_pick;
    logic                   w_cyc_raw;
    logic                   w_stb_raw;
    logic                   w_own_cyc;
    logic                   w_kill;
    logic                   w_to_hit;

    wb_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req_i  (m_cyc_i),
        .last_i (last_q),
        .gnt_o  (w_pick)
    );

    // Owner's signals onto the slave port; grant_q is zero in IDLE so all
    // slave outputs fall to zero there (and asynchronously on reset).
    always_comb begin
        w_cyc_raw = 1'b0;
        w_stb_raw = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_cti_o   = '0;
        s_bte_o   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                w_cyc_raw = m_cyc_i[i];
                w_stb_raw = m_stb_i[i];
                s_we_o    = m_we_i[i];
                s_adr_o   = m_adr_i[i*AW +: AW];
                s_dat_o   = m_dat_i[i*DW +: DW];
                s_sel_o   = m_sel_i[i*SW +: SW];
                s_cti_o   = m_cti_i[i*3 +: 3];
                s_bte_o   = m_bte_i[i*2 +: 2];
            end
        end
    end

    assign w_own_cyc = |(grant_q & m_cyc_i);
    assign s_cyc_o   = w_cyc_raw & ~w_kill;
    assign s_stb_o   = w_stb_raw & ~w_kill;
    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = grant_q & {NUM_MASTERS{s_ack_i}};
    assign m_err_o   = grant_q & {NUM_MASTERS{s_err_i | w_to_hit}};
    assign grant_o   = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          kill_q, kill_d;

    assign w_to_hit = (state_q == BUSY) && !kill_q && (cnt_q == CW'(TIMEOUT));
    assign w_kill   = kill_q | w_to_hit;

    // Watchdog: count unterminated strobe cycles, latch the abort until IDLE.
    always_comb begin
        cnt_d  = cnt_q;
        kill_d = kill_q;
        if (state_q == IDLE) begin
            cnt_d  = '0;
            kill_d = 1'b0;
        end else begin
            if (s_ack_i || s_err_i) begin
                cnt_d = '0;
            end else if (s_stb_o) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (w_to_hit) begin
                kill_d = 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cnt_q  <= '0;
            kill_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            kill_q <= kill_d;
        end
    end
`else
    assign w_to_hit = 1'b0;
    assign w_kill   = 1'b0;
`endif

    // Next-state: arbitrate in IDLE, hold the grant until the owner drops cyc.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    grant_d = w_pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!w_own_cyc) begin
                    last_d  = grant_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= c_LAST_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_sdram_arbiter
//  Description : Scoreboard bench for wb_sdram_arbiter. Master drivers push
//                each issued beat into a per-master queue; a negedge monitor
//                compares slave-port beats and grant/ack/err routing against a
//                round-robin reference model. WB_ARB_TIMEOUT_EN adds a
//                watchdog scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_sdram_arbiter;
    import wb_arb_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic [2:0]    cti;
        logic [1:0]    bte;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          mcyc[NM];
    logic          mstb[NM];
    logic          mwe[NM];
    logic [AW-1:0] madr[NM];
    logic [DW-1:0] mdat[NM];
    logic [SW-1:0] msel[NM];
    logic [2:0]    mcti[NM];
    logic [1:0]    mbte[NM];

    logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [NM*3-1:0]  m_cti_i;
    logic [NM*2-1:0]  m_bte_i;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
    logic             s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [SW-1:0]    s_sel_o;
    logic [2:0]       s_cti_o;
    logic [1:0]       s_bte_o;
    logic [DW-1:0]    s_dat_i;
    logic             s_ack_i, s_err_i;

    // Pack per-master driver arrays onto the DUT buses.
    always_comb begin
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0;
        m_dat_i = '0; m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
        for (int i = 0; i < NM; i++) begin
            m_cyc_i[i] = mcyc[i];
            m_stb_i[i] = mstb[i];
            m_we_i[i]  = mwe[i];
            m_adr_i[i*AW +: AW] = madr[i];
            m_dat_i[i*DW +: DW] = mdat[i];
            m_sel_i[i*SW +: SW] = msel[i];
            m_cti_i[i*3 +: 3]   = mcti[i];
            m_bte_i[i*2 +: 2]   = mbte[i];
        end
    end

    wb_sdram_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t expq[NM][$];
    int    gnt_log[$];
    bit    mon_en = 1'b1;
    int    slave_mode = 0;
    bit    err_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: bus owner (-1 = free) and last owner; arbitration happens one
    // cycle after the bus becomes free, choosing the first requester after last.
    int owner  = -1;
    int last_m = NM - 1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  = -1;
            last_m = NM - 1;
        end else if (owner < 0) begin
            for (int k = 1; k <= NM; k++) begin
                if (owner < 0 && mcyc[(last_m + k) % NM]) owner = (last_m + k) % NM;
            end
        end else if (!mcyc[owner]) begin
            last_m = owner;
            owner  = -1;
        end
    end

    // Monitor: routing checks every cycle, scoreboard pop on each terminated beat.
    logic [NM-1:0] exp_g;
    logic [NM-1:0] prev_g = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (owner < 0) begin
                chk("idle_grant", grant_o, 0);
                chk("idle_s_cyc", s_cyc_o, 0);
                chk("idle_s_stb", s_stb_o, 0);
                chk("idle_s_adr", s_adr_o, 0);
                chk("idle_ack", m_ack_o, 0);
                chk("idle_err", m_err_o, 0);
            end else begin
                exp_g = NM'(1) << owner;
                chk("grant", grant_o, exp_g);
                chk("s_cyc", s_cyc_o, mcyc[owner]);
                chk("s_stb", s_stb_o, mstb[owner]);
                chk("m_ack", m_ack_o, s_ack_i ? exp_g : '0);
                chk("m_err", m_err_o, s_err_i ? exp_g : '0);
                if (s_stb_o && (s_ack_i || s_err_i)) begin
                    if (expq[owner].size() == 0) begin
                        chk("beat_expected", 0, 1);
                    end else begin
                        beat_t b;
                        b = expq[owner].pop_front();
                        chk("s_adr", s_adr_o, b.adr);
                        chk("s_we", s_we_o, b.we);
                        chk("s_dat", s_dat_o, b.dat);
                        chk("s_sel", s_sel_o, b.sel);
                        chk("s_cti", s_cti_o, b.cti);
                        chk("s_bte", s_bte_o, b.bte);
                    end
                end
            end
            chk("m_dat", m_dat_o, s_dat_i);
        end
        if (grant_o != '0 && grant_o != prev_g) begin
            for (int i = 0; i < NM; i++) if (grant_o[i]) gnt_log.push_back(i);
        end
        prev_g = grant_o;
    end

    // Slave model: random wait states, optional error terminations.
    initial begin
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
        forever begin
            int r;
            @(posedge clk); #2;
            r = $urandom_range(0, 9);
            s_ack_i = (slave_mode == 0) && s_cyc_o && s_stb_o && (r < 6);
            s_err_i = (slave_mode == 0) && err_en && s_cyc_o && s_stb_o && (r == 6);
            s_dat_i = $urandom;
        end
    end

    // One Wishbone bus cycle of nbeats beats from master m, after gap cycles.
    task automatic run_master(input int m, input int nbeats, input int gap);
        beat_t b;
        bit    done;
        bit    got_err;
        int    w;
        @(posedge clk);
        repeat (gap) @(posedge clk);
        #1;
        mcyc[m] = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            b.adr = $urandom;
            b.we  = 1'($urandom_range(0, 1));
            b.dat = $urandom;
            b.sel = SW'($urandom);
            b.cti = (nbeats == 1) ? c_CTI_CLASSIC : ((i == nbeats - 1) ? c_CTI_EOB : c_CTI_INCR);
            b.bte = 2'b00;
            mstb[m] = 1'b1; madr[m] = b.adr; mwe[m] = b.we; mdat[m] = b.dat;
            msel[m] = b.sel; mcti[m] = b.cti; mbte[m] = b.bte;
            expq[m].push_back(b);
            done = 1'b0; got_err = 1'b0; w = 0;
            while (!done) begin
                @(negedge clk);
                w++;
                if (!rst_n) break;
                if (m_ack_o[m] || m_err_o[m]) begin
                    done = 1'b1;
                    got_err = m_err_o[m];
                end else if (w > 400) begin
                    n_cmp++; n_bad++;
                    $display("FAIL master%0d_wait: got no termination, expected ack within 400 cycles", m);
                    break;
                end
            end
            if (!done) break;
            @(posedge clk); #1;
            if (got_err) break;
        end
        mcyc[m] = 1'b0;
        mstb[m] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NM; i++) expq[i].delete();
        rst_n = 1'b1;
    endtask

    task automatic chk_log(input string nm, input int n, input int e0, input int e1,
                           input int e2, input int e3, input int e4, input int e5);
        int e[6];
        e = '{e0, e1, e2, e3, e4, e5};
        chk({nm, "_len"}, gnt_log.size(), n);
        for (int i = 0; i < n && i < gnt_log.size(); i++) chk({nm, "_order"}, gnt_log[i], e[i]);
        gnt_log.delete();
    endtask

    initial begin
        for (int i = 0; i < NM; i++) begin
            mcyc[i] = 0; mstb[i] = 0; mwe[i] = 0; madr[i] = '0;
            mdat[i] = '0; msel[i] = '0; mcti[i] = '0; mbte[i] = '0;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_s_cyc", s_cyc_o, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single read from master 1 only.
        gnt_log.delete();
        run_master(1, 1, 0);
        repeat (3) @(posedge clk);
        chk_log("single_m1", 1, 1, 0, 0, 0, 0, 0);

        // Simultaneous requests after reset: 0, 1, 2.
        do_reset(); gnt_log.delete();
        fork
            run_master(0, 1, 0);
            run_master(1, 1, 0);
            run_master(2, 1, 0);
        join
        repeat (3) @(posedge clk);
        chk_log("simul", 3, 0, 1, 2, 0, 0, 0);

        // 8-beat burst on master 0 is not split by master 2.
        fork
            run_master(0, 8, 0);
            run_master(2, 1, 1);
        join
        repeat (3) @(posedge clk);
        chk_log("burst", 2, 0, 2, 0, 0, 0, 0);

        // Continuous requesters alternate.
        do_reset(); gnt_log.delete();
        fork
            begin repeat (3) run_master(0, 2, 0); end
            begin repeat (3) run_master(1, 2, 0); end
        join
        repeat (3) @(posedge clk);
        chk_log("alternate", 6, 0, 1, 0, 1, 0, 1);

        // Reset mid-burst: outputs clear immediately, master 0 wins afterwards.
        gnt_log.delete();
        fork
            run_master(1, 8, 0);
            begin
                int w;
                w = 0;
                while (!s_cyc_o && w < 50) begin @(negedge clk); w++; end
                chk("midrst_started", s_cyc_o, 1);
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("midrst_s_cyc", s_cyc_o, 0);
                chk("midrst_grant", grant_o, 0);
                chk("midrst_ack", m_ack_o, 0);
                chk("midrst_err", m_err_o, 0);
                repeat (2) @(posedge clk);
                #1;
                for (int i = 0; i < NM; i++) expq[i].delete();
                rst_n = 1'b1;
            end
        join
        gnt_log.delete();
        fork
            run_master(2, 1, 0);
            run_master(1, 1, 0);
            run_master(0, 1, 0);
        join
        repeat (3) @(posedge clk);
        chk_log("post_rst", 3, 0, 1, 2, 0, 0, 0);

        // Randomised traffic with occasional slave errors.
        err_en = 1'b1;
        repeat (25) begin
            fork
                begin repeat ($urandom_range(1, 3)) run_master(0, $urandom_range(1, 4), $urandom_range(0, 3)); end
                begin repeat ($urandom_range(1, 3)) run_master(1, $urandom_range(1, 4), $urandom_range(0, 3)); end
                begin repeat ($urandom_range(1, 3)) run_master(2, $urandom_range(1, 4), $urandom_range(0, 3)); end
            join
        end
        err_en = 1'b0;
        repeat (3) @(posedge clk);
        gnt_log.delete();

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: slave never terminates.
        mon_en = 1'b0;
        do_reset(); gnt_log.delete();
        slave_mode = 1;
        fork
            run_master(1, 1, 0);
            begin
                int c;
                c = 0;
                while (!s_stb_o && c < 50) begin @(negedge clk); c++; end
                chk("to_stb_seen", s_stb_o, 1);
                c = 0;
                while (m_err_o == '0 && c < 100) begin @(negedge clk); c++; end
                chk("to_cycles", c, 16);
                chk("to_err", m_err_o, 3'b010);
                chk("to_stb_kill", s_stb_o, 0);
                chk("to_cyc_kill", s_cyc_o, 0);
                @(negedge clk);
                chk("to_err_pulse", m_err_o, 0);
                chk("to_cyc_low", s_cyc_o, 0);
            end
            run_master(2, 1, 3);
        join
        repeat (3) @(posedge clk);
        chk_log("to_next", 2, 1, 2, 0, 0, 0, 0);
        slave_mode = 0;
        for (int i = 0; i < NM; i++) expq[i].delete();
        mon_en = 1'b1;
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
